// File: rtl/compare_sequencer_pkg.sv
// Shared constants and types for the compare sequencer.
// Select codes, operand width and FSM state encoding.
package compare_sequencer_pkg;

  localparam int OPW = 4;

  localparam logic [1:0] SEL_EQ  = 2'b00;
  localparam logic [1:0] SEL_GR  = 2'b01;
  localparam logic [1:0] SEL_LS  = 2'b10;
  localparam logic [1:0] SEL_MAX = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    STEP = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/compare_sequencer_rise.sv
// Registered rising-edge detector, one bit wide.
// History register updates every cycle.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_in,
  output logic o_rise
);

  logic r_q;

  // Keep last-cycle level for edge comparison
  always_ff @(posedge clk) begin
    if (reset) r_q <= 1'b0;
    else       r_q <= i_in;
  end

  assign o_rise = i_in & ~r_q;

endmodule

// File: rtl/compare_sequencer.sv
// Operand-side driver for the 4-bit comparison block.
// Steps the select through eq/gr/ls/max and holds results.
module compare_sequencer
  import compare_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] sw_in,
  input  logic           load_a,
  input  logic           load_b,
  input  logic           start,
  output logic [7:0]     cmp_numi,
  output logic [1:0]     cmp_sel,
  input  logic [7:0]     cmp_numo,
  output logic           busy,
  output logic           done,
  output logic           eq,
  output logic           gr,
  output logic           ls,
  output logic [OPW-1:0] max,
  output logic           err
);

  localparam int CW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  state_t         r_state, w_state_n;
  logic [OPW-1:0] r_a, w_a_n;
  logic [OPW-1:0] r_b, w_b_n;
  logic [1:0]     r_sel, w_sel_n;
  logic [CW-1:0]  r_cnt, w_cnt_n;
  logic           r_eq, w_eq_n;
  logic           r_gr, w_gr_n;
  logic           r_ls, w_ls_n;
  logic [OPW-1:0] r_max, w_max_n;
  logic           r_err, w_err_n;
  logic           r_bad, w_bad_n;

  logic           w_rise_a;
  logic           w_rise_b;
  logic           w_rise_s;
  logic [OPW-1:0] w_lmax;
  logic [1:0]     w_sum;

  rise_detect u_rise_a (
    .clk    (clk),
    .reset  (reset),
    .i_in   (load_a),
    .o_rise (w_rise_a)
  );

  rise_detect u_rise_b (
    .clk    (clk),
    .reset  (reset),
    .i_in   (load_b),
    .o_rise (w_rise_b)
  );

  rise_detect u_rise_s (
    .clk    (clk),
    .reset  (reset),
    .i_in   (start),
    .o_rise (w_rise_s)
  );

  assign w_lmax = (r_a > r_b) ? r_a : r_b;
  assign w_sum  = {1'b0, r_eq} + {1'b0, r_gr}
                + {1'b0, r_ls};

  // Next-state, operand capture and result sampling
  always_comb begin
    w_state_n = r_state;
    w_a_n     = r_a;
    w_b_n     = r_b;
    w_sel_n   = r_sel;
    w_cnt_n   = r_cnt;
    w_eq_n    = r_eq;
    w_gr_n    = r_gr;
    w_ls_n    = r_ls;
    w_max_n   = r_max;
    w_err_n   = r_err;
    w_bad_n   = r_bad;
    unique case (r_state)
      IDLE, DONE: begin
        if (w_rise_a) w_a_n = sw_in;
        if (w_rise_b) w_b_n = sw_in;
        if (w_rise_a || w_rise_b || w_rise_s) begin
          w_eq_n  = 1'b0;
          w_gr_n  = 1'b0;
          w_ls_n  = 1'b0;
          w_max_n = '0;
          w_err_n = 1'b0;
        end
        if ((r_state == DONE) && (w_rise_a || w_rise_b))
          w_state_n = IDLE;
        if (w_rise_s) begin
          w_state_n = STEP;
          w_sel_n   = SEL_EQ;
          w_cnt_n   = '0;
          w_bad_n   = 1'b0;
        end
      end
      STEP: begin
        if (r_cnt == LAST) begin
          w_cnt_n = '0;
          unique case (r_sel)
            SEL_EQ: begin
              w_eq_n  = cmp_numo[0];
              w_bad_n = r_bad | (|cmp_numo[7:1]);
              w_sel_n = SEL_GR;
            end
            SEL_GR: begin
              w_gr_n  = cmp_numo[0];
              w_bad_n = r_bad | (|cmp_numo[7:1]);
              w_sel_n = SEL_LS;
            end
            SEL_LS: begin
              w_ls_n  = cmp_numo[0];
              w_bad_n = r_bad | (|cmp_numo[7:1]);
              w_sel_n = SEL_MAX;
            end
            SEL_MAX: begin
              w_max_n   = cmp_numo[3:0];
              w_sel_n   = SEL_EQ;
              w_state_n = DONE;
              w_err_n   = r_bad
                        | (|cmp_numo[7:4])
                        | (w_sum != 2'd1)
                        | (cmp_numo[3:0] != w_lmax);
            end
            default: w_sel_n = SEL_EQ;
          endcase
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sel   <= SEL_EQ;
      r_cnt   <= '0;
      r_eq    <= 1'b0;
      r_gr    <= 1'b0;
      r_ls    <= 1'b0;
      r_max   <= '0;
      r_err   <= 1'b0;
      r_bad   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_a     <= w_a_n;
      r_b     <= w_b_n;
      r_sel   <= w_sel_n;
      r_cnt   <= w_cnt_n;
      r_eq    <= w_eq_n;
      r_gr    <= w_gr_n;
      r_ls    <= w_ls_n;
      r_max   <= w_max_n;
      r_err   <= w_err_n;
      r_bad   <= w_bad_n;
    end
  end

  assign cmp_numi = {r_a, r_b};
  assign cmp_sel  = r_sel;
  assign busy     = (r_state == STEP);
  assign done     = (r_state == DONE);
  assign eq       = r_eq;
  assign gr       = r_gr;
  assign ls       = r_ls;
  assign max      = r_max;
  assign err      = r_err;

endmodule

// File: tb/tb_compare_sequencer.sv
// Self-checking bench for compare_sequencer.
// Behavioural comparator plus arithmetic reference model.
module tb_compare_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sw_in = '0;
  logic       load_a = 1'b0;
  logic       load_b = 1'b0;
  logic       start = 1'b0;
  logic [7:0] cmp_numi;
  logic [1:0] cmp_sel;
  logic [7:0] cmp_numo;
  logic       busy, done, eq, gr, ls, err;
  logic [3:0] max;
  bit         fault = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  compare_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_in    (sw_in),
    .load_a   (load_a),
    .load_b   (load_b),
    .start    (start),
    .cmp_numi (cmp_numi),
    .cmp_sel  (cmp_sel),
    .cmp_numo (cmp_numo),
    .busy     (busy),
    .done     (done),
    .eq       (eq),
    .gr       (gr),
    .ls       (ls),
    .max      (max),
    .err      (err)
  );

  // Behavioural comparator, with an optional bad eq response
  wire [3:0] ca = cmp_numi[7:4];
  wire [3:0] cb = cmp_numi[3:0];
  assign cmp_numo =
    (fault && cmp_sel == 2'b00) ? 8'h03 :
    (cmp_sel == 2'b00) ? {7'd0, ca == cb} :
    (cmp_sel == 2'b01) ? {7'd0, ca > cb} :
    (cmp_sel == 2'b10) ? {7'd0, ca < cb} :
    {4'd0, (ca > cb) ? ca : cb};

  function automatic logic [15:0] exp_trace();
    logic [15:0] t;
    for (int c = 0; c < 8; c++) t[2*c +: 2] = 2'(c / 2);
    return t;
  endfunction

  // Results packed as {eq,gr,ls,max,err}
  function automatic logic [7:0] model(
    input logic [3:0] a, input logic [3:0] b, input bit f);
    logic e, g, l, x;
    logic [3:0] m;
    e = f ? 1'b1 : (a == b);
    g = (a > b);
    l = (a < b);
    m = (a > b) ? a : b;
    x = f || ((int'(e) + int'(g) + int'(l)) != 1);
    return {e, g, l, m, x};
  endfunction

  task automatic load_ops(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    sw_in = a; load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0; sw_in = b; load_b = 1'b1;
    @(negedge clk);
    load_b = 1'b0;
  endtask

  // Pulse start, record sel/busy for cycles 1..8, end in cycle 9
  task automatic drive_seq(input bit inject,
                           output logic [15:0] tr,
                           output logic [7:0] bz);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tr[2*(c-1) +: 2] = cmp_sel;
      bz[c-1] = busy & ~done;
      if (inject && c == 2) start = 1'b1;
      if (inject && c == 3) begin
        sw_in = 4'd1; load_a = 1'b1; start = 1'b0;
      end
      if (inject && c == 4) load_a = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, eq, gr, ls, err, max, cmp_sel, cmp_numi} !== '0)
    begin
      errors++;
      $display("FAIL reset_state got %b%b%b%b%b%b %h %b %h want 0",
               busy, done, eq, gr, ls, err, max, cmp_sel, cmp_numi);
    end
    reset = 1'b0;
  endtask

  task automatic run_case(input string nm,
                          input logic [3:0] a, input logic [3:0] b);
    logic [15:0] tr;
    logic [7:0]  bz;
    logic [7:0]  exp;
    load_ops(a, b);
    drive_seq(1'b0, tr, bz);
    exp = model(a, b, fault);
    checks++;
    if (tr !== exp_trace() || bz !== 8'hFF) begin
      errors++;
      $display("FAIL %s_trace sel=%h busy=%h want %h FF",
               nm, tr, bz, exp_trace());
    end
    checks++;
    if ({done, busy, cmp_sel} !== 4'b1000) begin
      errors++;
      $display("FAIL %s_done done=%b busy=%b sel=%b want 1 0 00",
               nm, done, busy, cmp_sel);
    end
    checks++;
    if ({eq, gr, ls, max, err} !== exp) begin
      errors++;
      $display("FAIL %s_res got %b want %b", nm,
               {eq, gr, ls, max, err}, exp);
    end
    checks++;
    if (cmp_numi !== {a, b}) begin
      errors++;
      $display("FAIL %s_numi got %h want %h", nm, cmp_numi, {a, b});
    end
  endtask

  task automatic test_basic();
    run_case("a9b3", 4'd9, 4'd3);
    run_case("a5b5", 4'd5, 4'd5);
    run_case("a2b14", 4'd2, 4'd14);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_case("rand", 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)));
    end
  endtask

  task automatic test_fault();
    fault = 1'b1;
    run_case("fault", 4'd9, 4'd3);
    fault = 1'b0;
  endtask

  task automatic test_hold_and_clear();
    logic [7:0] exp;
    run_case("hold", 4'd12, 4'd4);
    exp = model(4'd12, 4'd4, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || {eq, gr, ls, max, err} !== exp) begin
      errors++;
      $display("FAIL hold_results done=%b res=%b want 1 %b",
               done, {eq, gr, ls, max, err}, exp);
    end
    sw_in = 4'd4; load_b = 1'b1;
    @(negedge clk);
    load_b = 1'b0;
    checks++;
    if ({done, busy, eq, gr, ls, max, err} !== '0 ||
        cmp_numi !== 8'hC4) begin
      errors++;
      $display("FAIL load_clears done=%b res=%b numi=%h want 0 0 C4",
               done, {eq, gr, ls, max, err}, cmp_numi);
    end
  endtask

  task automatic test_ignore_busy();
    logic [15:0] tr;
    logic [7:0]  bz;
    load_ops(4'd9, 4'd3);
    drive_seq(1'b1, tr, bz);
    checks++;
    if (tr !== exp_trace() || bz !== 8'hFF) begin
      errors++;
      $display("FAIL ign_trace sel=%h busy=%h want %h FF",
               tr, bz, exp_trace());
    end
    checks++;
    if (done !== 1'b1 || cmp_numi !== 8'h93 ||
        {eq, gr, ls, max, err} !== model(4'd9, 4'd3, 1'b0)) begin
      errors++;
      $display("FAIL ign_result done=%b numi=%h res=%b want 1 93 %b",
               done, cmp_numi, {eq, gr, ls, max, err},
               model(4'd9, 4'd3, 1'b0));
    end
  endtask

  task automatic test_reset_mid();
    load_ops(4'd6, 4'd10);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got %b want 1", busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, eq, gr, ls, err, max, cmp_sel, cmp_numi} !== '0)
    begin
      errors++;
      $display("FAIL mid_reset got %b%b%b%b%b%b %h %b %h want 0",
               busy, done, eq, gr, ls, err, max, cmp_sel, cmp_numi);
    end
    run_case("after_rst", 4'd6, 4'd10);
  endtask

  task automatic test_load_start_same();
    load_ops(4'd1, 4'd2);
    @(negedge clk);
    sw_in = 4'd7; load_b = 1'b1; start = 1'b1;
    @(negedge clk);
    load_b = 1'b0; start = 1'b0;
    checks++;
    if (cmp_numi !== 8'h17 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ls_same_c1 numi=%h busy=%b want 17 1",
               cmp_numi, busy);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (done !== 1'b1 ||
        {eq, gr, ls, max, err} !== model(4'd1, 4'd7, 1'b0)) begin
      errors++;
      $display("FAIL ls_same_res done=%b res=%b want 1 %b", done,
               {eq, gr, ls, max, err}, model(4'd1, 4'd7, 1'b0));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fault();
    test_random();
    test_hold_and_clear();
    test_ignore_busy();
    test_reset_mid();
    test_load_start_same();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
